// File: rtl/axi_lite_pkg.sv
// Shared types and helpers for the AXI4-Lite write slave.
// Holds the response codes, the write-path state encoding and the address window check.
package axi_lite_pkg;

    typedef enum logic [1:0] {
        RespOkay   = 2'b00,
        RespExOkay = 2'b01,
        RespSlvErr = 2'b10,
        RespDecErr = 2'b11
    } resp_t;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StHaveAw = 3'd1,
        StHaveW  = 3'd2,
        StWrite  = 3'd3,
        StResp   = 3'd4
    } wr_state_t;

    // Arguments are zero-extended to 64 bits so one function serves every address width.
    function automatic logic addr_in_range(input logic [63:0] addr,
                                           input logic [63:0] base,
                                           input logic [63:0] size);
        return (addr >= base) && ((addr - base) < size);
    endfunction

endpackage

// File: rtl/axi_lite_ack_timer.sv
// Ack timeout counter for the write slave's back-end request.
// Flags expiry after ACK_TIMEOUT enabled cycles; ACK_TIMEOUT=0 never expires.
module axi_lite_ack_timer #(
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic clk,
    input  logic i_reset,
    input  logic i_en,
    input  logic i_clr,
    output logic o_expired
);

    localparam int unsigned CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = (ACK_TIMEOUT == 0) ? '0 : CW'(ACK_TIMEOUT - 1);

    logic [CW-1:0] count_q, count_d;

    // Expiry fires on the last waiting cycle so the request is held exactly ACK_TIMEOUT cycles.
    assign o_expired = (ACK_TIMEOUT != 0) && i_en && (count_q == LAST);

    always_comb begin
        count_d = count_q + 1'b1;
        if (i_clr || !i_en || o_expired) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!i_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/axi_lite_write_slave.sv
// AXI4-Lite write-channel slave: joins AW and W, decodes the window, issues one
// back-end write at a time and returns the B response.
module axi_lite_write_slave
    import axi_lite_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH  = 32,
    parameter int unsigned            DATA_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0]  ADDR_BASE   = 32'h0000_0000,
    parameter logic [ADDR_WIDTH-1:0]  ADDR_SIZE   = 32'h0000_1000,
    parameter int unsigned            ACK_TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      i_reset,
    input  logic [ADDR_WIDTH-1:0]     i_awaddr,
    input  logic                      i_awvalid,
    output logic                      o_awready,
    input  logic [DATA_WIDTH-1:0]     i_wdata,
    input  logic [DATA_WIDTH/8-1:0]   i_wstrb,
    input  logic                      i_wvalid,
    output logic                      o_wready,
    output logic [1:0]                o_bresp,
    output logic                      o_bvalid,
    input  logic                      i_bready,
    output logic                      o_wr_en,
    output logic [ADDR_WIDTH-1:0]     o_wr_addr,
    output logic [DATA_WIDTH-1:0]     o_wr_data,
    output logic [DATA_WIDTH/8-1:0]   o_wr_strb,
    input  logic                      i_wr_ack,
    input  logic                      i_wr_err
);

    localparam int unsigned SW = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(SW - 1);

    wr_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [SW-1:0]         w_strb_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic [SW-1:0]         wr_strb_q;
    resp_t                 bresp_q, bresp_d;

    logic                  aw_hs, w_hs, complete, in_range, expired;
    logic [ADDR_WIDTH-1:0] dec_addr, dec_offset;
    logic [DATA_WIDTH-1:0] dec_data;
    logic [SW-1:0]         dec_strb;

    // Readies come from registered state only.
    assign o_awready = (state_q == StIdle) || (state_q == StHaveW);
    assign o_wready  = (state_q == StIdle) || (state_q == StHaveAw);
    assign o_wr_en   = (state_q == StWrite);
    assign o_bvalid  = (state_q == StResp);
    assign o_bresp   = bresp_q;
    assign o_wr_addr = wr_addr_q;
    assign o_wr_data = wr_data_q;
    assign o_wr_strb = wr_strb_q;

    assign aw_hs = i_awvalid && o_awready;
    assign w_hs  = i_wvalid && o_wready;

    // The channel that arrived first comes from its capture register, the other one is live.
    assign dec_addr   = (state_q == StHaveAw) ? aw_addr_q : i_awaddr;
    assign dec_data   = (state_q == StHaveW) ? w_data_q : i_wdata;
    assign dec_strb   = (state_q == StHaveW) ? w_strb_q : i_wstrb;
    assign dec_offset = (dec_addr - ADDR_BASE) & ~ALIGN_MASK;
    assign in_range   = addr_in_range(64'(dec_addr), 64'(ADDR_BASE), 64'(ADDR_SIZE));

    assign complete = ((state_q == StIdle) && aw_hs && w_hs) ||
                      ((state_q == StHaveAw) && w_hs) ||
                      ((state_q == StHaveW) && aw_hs);

    axi_lite_ack_timer #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_ack_timer (
        .clk       (clk),
        .i_reset   (i_reset),
        .i_en      (o_wr_en),
        .i_clr     (i_wr_ack),
        .o_expired (expired)
    );

    always_comb begin
        state_d = state_q;
        bresp_d = bresp_q;
        unique case (state_q)
            StIdle: begin
                if (aw_hs && !w_hs) begin
                    state_d = StHaveAw;
                end else if (w_hs && !aw_hs) begin
                    state_d = StHaveW;
                end
            end
            StHaveAw, StHaveW: ;
            StWrite: begin
                // An ack in the expiry cycle takes priority over the timeout.
                if (i_wr_ack) begin
                    state_d = StResp;
                    bresp_d = i_wr_err ? RespSlvErr : RespOkay;
                end else if (expired) begin
                    state_d = StResp;
                    bresp_d = RespSlvErr;
                end
            end
            StResp: begin
                if (i_bready) begin
                    state_d = StIdle;
                    bresp_d = RespOkay;
                end
            end
            default: state_d = StIdle;
        endcase
        if (complete) begin
            state_d = in_range ? StWrite : StResp;
            bresp_d = in_range ? RespOkay : RespDecErr;
        end
    end

    always_ff @(posedge clk) begin
        if (!i_reset) begin
            state_q   <= StIdle;
            bresp_q   <= RespOkay;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_strb_q <= '0;
        end else begin
            state_q <= state_d;
            bresp_q <= bresp_d;
            if (aw_hs) begin
                aw_addr_q <= i_awaddr;
            end
            if (w_hs) begin
                w_data_q <= i_wdata;
                w_strb_q <= i_wstrb;
            end
            if (complete && in_range) begin
                wr_addr_q <= dec_offset;
                wr_data_q <= dec_data;
                wr_strb_q <= dec_strb;
            end
        end
    end

endmodule
